// File: rtl/bram_cmd_pkg.sv
// Shared constants, state encodings and command/status helpers for the BRAM command fetch stage.
package bram_cmd_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MODE_W     = 3;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STATE_W    = 6;
  localparam int unsigned WE_W       = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CMD_ADDR   = 0;

  // Command word field positions
  localparam int unsigned CMD_START_BIT = 0;
  localparam int unsigned CMD_MODE_LSB  = 1;
  localparam int unsigned CMD_CNT_LSB   = 8;

  // Status word field positions
  localparam int unsigned STS_DONE_BIT = 31;
  localparam int unsigned STS_ERR_BIT  = 30;
  localparam int unsigned STS_CNT_LSB  = 8;
  localparam int unsigned STS_MODE_LSB = 1;

  // One-hot state encodings, also exported on DEBUG_state
  localparam logic [STATE_W-1:0] ST_POLL   = 6'b000001;
  localparam logic [STATE_W-1:0] ST_PWAIT  = 6'b000010;
  localparam logic [STATE_W-1:0] ST_DECODE = 6'b000100;
  localparam logic [STATE_W-1:0] ST_FETCH  = 6'b001000;
  localparam logic [STATE_W-1:0] ST_DRAIN  = 6'b010000;
  localparam logic [STATE_W-1:0] ST_WB     = 6'b100000;

  typedef enum logic [STATE_W-1:0] {
    S_POLL   = ST_POLL,
    S_PWAIT  = ST_PWAIT,
    S_DECODE = ST_DECODE,
    S_FETCH  = ST_FETCH,
    S_DRAIN  = ST_DRAIN,
    S_WB     = ST_WB
  } state_e;

  // Decoded command fields kept in cmd_reg
  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [MODE_W-1:0] mode;
    logic              start;
  } cmd_t;

  // Extract the meaningful fields of a raw command word
  function automatic cmd_t decode_cmd(input logic [DATA_W-1:0] word);
    cmd_t c;
    c.start = word[CMD_START_BIT];
    c.mode  = word[CMD_MODE_LSB +: MODE_W];
    c.count = word[CMD_CNT_LSB +: CNT_W];
    return c;
  endfunction

  // Build the writeback word; start bit position is left at 0 so the host sees the command consumed
  function automatic logic [DATA_W-1:0] make_status(input logic              err,
                                                     input logic [CNT_W-1:0]  cnt,
                                                     input logic [MODE_W-1:0] mode);
    logic [DATA_W-1:0] s;
    s = '0;
    s[STS_DONE_BIT] = 1'b1;
    s[STS_ERR_BIT]  = err;
    s[STS_CNT_LSB +: CNT_W]   = err ? '0 : cnt;
    s[STS_MODE_LSB +: MODE_W] = mode;
    return s;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry operand buffer with registered head outputs; push and pop may coincide when full.
module fetch_skid_fifo
  import bram_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d;
  logic              tail_last_q, tail_last_d;
  logic [1:0]        count_q, count_d;
  logic              valid_q, valid_d;
  logic              pop_c;

  assign pop_c = pop_i && valid_q;

  // Next-state for the head/tail slots and occupancy
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    case ({push_i, pop_c})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = data_i;
          head_last_d = last_i;
          count_d     = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_data_d = data_i;
          tail_last_d = last_i;
          count_d     = 2'd2;
        end
      end
      2'b01: begin
        head_data_d = tail_data_q;
        // Keep the held data but never show a stale last flag once empty
        head_last_d = (count_q == 2'd2) ? tail_last_q : 1'b0;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = data_i;
          head_last_d = last_i;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = data_i;
          tail_last_d = last_i;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  // Slot and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= 2'd0;
      valid_q     <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_data_q;
  assign last_o  = head_last_q;
  assign count_o = count_q;

endmodule

// File: rtl/bram_cmd_fetch.sv
// Polls the command word at BRAM address 0, streams the following operand words, writes status back.
module bram_cmd_fetch
  import bram_cmd_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1023,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               bram_en,
  output logic [WE_W-1:0]    bram_we,
  output logic [DATA_W-1:0]  bram_din,
  input  logic [DATA_W-1:0]  bram_dout,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [MODE_W-1:0]  m_mode,
  output logic [STATE_W-1:0] DEBUG_state
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              live_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_last_q;

  logic              fifo_valid, fifo_last;
  logic [DATA_W-1:0] fifo_data;
  logic [1:0]        fifo_count;

  logic              pop_c, issue_c, last_issue_c, drain_done_c, too_big_c;

  assign pop_c        = fifo_valid && m_ready;
  assign last_issue_c = (issued_q + CNT_W'(1)) == cmd_q.count;
  assign too_big_c    = 32'(cmd_q.count) > 32'(MAX_WORDS);

  // A beat leaving this cycle frees its slot, so the credit check subtracts it
  assign issue_c = (state_q == S_FETCH) && (issued_q < cmd_q.count) &&
                   ((3'(fifo_count) + 3'(rd_pend_q)) < (3'd2 + 3'(pop_c)));

  assign drain_done_c = !rd_pend_q &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop_c));

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    issued_d  = issued_q;
    rd_addr_d = rd_addr_q;
    sent_d    = sent_q + CNT_W'(pop_c);
    case (state_q)
      S_POLL: begin
        // The first cycle out of reset has no read on the port, so stay until one is issued
        if (live_q) state_d = S_PWAIT;
      end
      S_PWAIT: begin
        cmd_d   = decode_cmd(bram_dout);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        issued_d  = '0;
        sent_d    = '0;
        err_d     = 1'b0;
        rd_addr_d = ADDR_W'(WORD_BYTES);
        if (!cmd_q.start) begin
          state_d = S_POLL;
        end else if (cmd_q.count == '0) begin
          state_d = S_WB;
        end else if (too_big_c) begin
          err_d   = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue_c) begin
          issued_d  = issued_q + CNT_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(WORD_BYTES);
          if (last_issue_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done_c) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_POLL;
      end
      default: begin
        state_d = S_POLL;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_POLL;
      cmd_q     <= '0;
      live_q    <= 1'b0;
      err_q     <= 1'b0;
      issued_q  <= '0;
      sent_q    <= '0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      live_q    <= 1'b1;
      err_q     <= err_d;
      issued_q  <= issued_d;
      sent_q    <= sent_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= issue_c;
      rd_last_q <= issue_c && last_issue_c;
    end
  end

  // BRAM port: poll read, operand reads gated by credit, single status write
  always_comb begin
    bram_en   = 1'b0;
    bram_addr = ADDR_W'(CMD_ADDR);
    bram_we   = '0;
    bram_din  = '0;
    if (issue_c) begin
      bram_en   = 1'b1;
      bram_addr = rd_addr_q;
    end else if ((state_q == S_POLL) && live_q) begin
      bram_en = 1'b1;
    end else if (state_q == S_WB) begin
      bram_en  = 1'b1;
      bram_we  = '1;
      bram_din = make_status(err_q, sent_q, cmd_q.mode);
    end
  end

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_pend_q),
    .data_i  (bram_dout),
    .last_i  (rd_last_q),
    .pop_i   (m_ready),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .last_o  (fifo_last),
    .count_o (fifo_count)
  );

  assign m_valid     = fifo_valid;
  assign m_data      = fifo_data;
  assign m_last      = fifo_last;
  assign m_mode      = cmd_q.mode;
  assign DEBUG_state = state_q;

endmodule
